// File: rtl/trigger.sv
// Trigger front-end: picks one of three trigger sources, synchronizes and edge-detects it,
// emits a dead-time-protected one-clock pulse and frames pulses into acquisition cycles.
module trigger #(
  parameter int SYNC_STAGES = 2,
  parameter int DEADTIME    = 8,
  parameter int GAP_TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigin,
  input  logic       trigcpu,
  input  logic       trigemu,
  input  logic [1:0] trigsel,
  output logic       trigpulse,
  output logic       cycleend,
  output logic       cyclebegin
);
  localparam int DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME);
  localparam logic [DW-1:0] DEAD_ONE  = DW'(1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [2:0]             src;
  logic [SYNC_STAGES-1:0] sync_p0 [3];
  logic [1:0]             sel_p1;
  logic                   mux_p1;
  logic                   prev_p2;
  logic                   pulse_p3;
  logic                   sel_lvl;
  logic                   sel_chg;
  logic                   rise;
  logic                   fire;
  logic [DW-1:0]          dead;
  state_t                 state, state_n;
  logic [GW-1:0]          gap, gap_n;

  assign src = {trigemu, trigcpu, trigin};

  always_comb begin
    case (trigsel)
      2'd0:    sel_lvl = sync_p0[0][SYNC_STAGES-1];
      2'd1:    sel_lvl = sync_p0[1][SYNC_STAGES-1];
      2'd2:    sel_lvl = sync_p0[2][SYNC_STAGES-1];
      default: sel_lvl = 1'b0;
    endcase
  end

  // A select change re-seeds the previous level so switching sources never looks like an edge.
  assign sel_chg = (trigsel != sel_p1);
  assign rise    = mux_p1 & ~prev_p2 & ~sel_chg;
  assign fire    = rise && (dead == '0);

  // p0: synchronizers, p1: source mux, p2: previous level, p3: trigger pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) sync_p0[i] <= '1;
      sel_p1   <= trigsel;
      mux_p1   <= 1'b1;
      prev_p2  <= 1'b1;
      pulse_p3 <= 1'b0;
      dead     <= '0;
    end else begin
      for (int i = 0; i < 3; i++) sync_p0[i] <= {sync_p0[i][SYNC_STAGES-2:0], src[i]};
      sel_p1   <= trigsel;
      mux_p1   <= sel_lvl;
      prev_p2  <= sel_chg ? sel_lvl : mux_p1;
      pulse_p3 <= fire;
      if (fire)
        dead <= DEAD_LOAD;
      else if (dead != '0)
        dead <= dead - DEAD_ONE;
    end
  end

  assign trigpulse = pulse_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gap   <= '0;
    end else begin
      state <= state_n;
      gap   <= gap_n;
    end
  end

  // A pulse in the timeout cycle takes priority over ending the cycle.
  always_comb begin
    state_n    = state;
    gap_n      = gap;
    cyclebegin = 1'b0;
    cycleend   = 1'b0;
    case (state)
      IDLE: begin
        if (pulse_p3) begin
          cyclebegin = 1'b1;
          state_n    = ACTIVE;
          gap_n      = '0;
        end
      end
      ACTIVE: begin
        if (pulse_p3) begin
          gap_n = '0;
        end else if (gap >= GAP_LAST) begin
          cycleend = 1'b1;
          state_n  = IDLE;
          gap_n    = '0;
        end else begin
          gap_n = gap + GAP_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_trigger.sv
// Scoreboard bench for trigger: randomized and directed source activity against a
// timing-rule reference model of pulses, cycle starts and cycle ends.
module tb_trigger;
  localparam int SYNC_STAGES = 2;
  localparam int DEADTIME    = 8;
  localparam int GAP_TIMEOUT = 256;
  localparam int LAT         = SYNC_STAGES + 1;
  localparam int NMAX        = 14000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trigin = 1'b0, trigcpu = 1'b0, trigemu = 1'b0;
  logic [1:0] trigsel = 2'd0;
  logic       trigpulse, cycleend, cyclebegin;

  trigger #(.SYNC_STAGES(SYNC_STAGES), .DEADTIME(DEADTIME), .GAP_TIMEOUT(GAP_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .trigin(trigin), .trigcpu(trigcpu), .trigemu(trigemu),
    .trigsel(trigsel), .trigpulse(trigpulse), .cycleend(cycleend), .cyclebegin(cyclebegin)
  );

  always #3 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus per edge number (1-based) and expected {cyclebegin, cycleend, trigpulse}.
  bit       s_rst [0:NMAX];
  bit [2:0] s_in  [0:NMAX];
  bit [1:0] s_sel [0:NMAX];
  bit [2:0] e_ev  [0:NMAX];
  int       npt = 0;

  typedef struct packed {
    int       stamp;
    logic [2:0] kind;
  } ev_t;
  ev_t q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic hold(input int n, input bit r, input bit [2:0] lv, input bit [1:0] s);
    for (int k = 0; k < n; k++) begin
      if (npt < NMAX) begin
        npt++;
        s_rst[npt] = r;
        s_in[npt]  = lv;
        s_sel[npt] = s;
      end
    end
  endtask

  task automatic build_stim();
    bit [1:0] cs;
    bit [2:0] lv;
    int quiet, len;
    hold(17, 1'b1, 3'b000, 2'd0);
    hold(10, 1'b0, 3'b000, 2'd0);
    // two isolated pulses
    hold(3, 1'b0, 3'b001, 2'd0);  hold(333, 1'b0, 3'b000, 2'd0);
    hold(3, 1'b0, 3'b001, 2'd0);  hold(300, 1'b0, 3'b000, 2'd0);
    // held level
    hold(333, 1'b0, 3'b001, 2'd0); hold(300, 1'b0, 3'b000, 2'd0);
    // dead time: rises 4 apart, then 10 apart
    hold(2, 1'b0, 3'b001, 2'd0); hold(2, 1'b0, 3'b000, 2'd0);
    hold(2, 1'b0, 3'b001, 2'd0); hold(300, 1'b0, 3'b000, 2'd0);
    hold(2, 1'b0, 3'b001, 2'd0); hold(8, 1'b0, 3'b000, 2'd0);
    hold(2, 1'b0, 3'b001, 2'd0); hold(300, 1'b0, 3'b000, 2'd0);
    // cpu source selected, trigin ignored
    hold(10, 1'b0, 3'b000, 2'd1);
    hold(3, 1'b0, 3'b010, 2'd1); hold(20, 1'b0, 3'b000, 2'd1);
    hold(3, 1'b0, 3'b001, 2'd1); hold(20, 1'b0, 3'b000, 2'd1);
    hold(3, 1'b0, 3'b001, 2'd1); hold(300, 1'b0, 3'b000, 2'd1);
    // disabled
    hold(10, 1'b0, 3'b000, 2'd3);
    hold(3, 1'b0, 3'b001, 2'd3); hold(10, 1'b0, 3'b000, 2'd3);
    hold(3, 1'b0, 3'b010, 2'd3); hold(10, 1'b0, 3'b000, 2'd3);
    hold(3, 1'b0, 3'b100, 2'd3); hold(10, 1'b0, 3'b000, 2'd3);
    hold(3, 1'b0, 3'b111, 2'd3); hold(300, 1'b0, 3'b000, 2'd3);
    // select changes onto sources that are already high
    hold(10, 1'b0, 3'b000, 2'd0);
    hold(10, 1'b0, 3'b010, 2'd0); hold(20, 1'b0, 3'b010, 2'd1);
    hold(10, 1'b0, 3'b110, 2'd1); hold(20, 1'b0, 3'b110, 2'd2);
    hold(10, 1'b0, 3'b001, 2'd2); hold(20, 1'b0, 3'b001, 2'd0);
    hold(300, 1'b0, 3'b000, 2'd0);
    // reset while active, reset released with trigin high
    hold(3, 1'b0, 3'b001, 2'd0); hold(50, 1'b0, 3'b000, 2'd0);
    hold(5, 1'b1, 3'b000, 2'd0); hold(300, 1'b0, 3'b000, 2'd0);
    hold(5, 1'b1, 3'b001, 2'd0); hold(20, 1'b0, 3'b001, 2'd0);
    hold(300, 1'b0, 3'b000, 2'd0);
    // pulse exactly at the timeout cycle, then one cycle past it
    hold(3, 1'b0, 3'b001, 2'd0); hold(253, 1'b0, 3'b000, 2'd0);
    hold(3, 1'b0, 3'b001, 2'd0); hold(400, 1'b0, 3'b000, 2'd0);
    hold(3, 1'b0, 3'b001, 2'd0); hold(254, 1'b0, 3'b000, 2'd0);
    hold(3, 1'b0, 3'b001, 2'd0); hold(300, 1'b0, 3'b000, 2'd0);
    // random bursts, select fixed per segment, occasional reset
    cs = 2'd0;
    for (int seg = 0; seg < 6; seg++) begin
      hold(8, 1'b0, 3'b000, cs);
      cs = 2'($urandom_range(0, 3));
      hold(8, 1'b0, 3'b000, cs);
      lv = 3'b000;
      quiet = 0;
      len = $urandom_range(400, 700);
      for (int k = 0; k < len; k++) begin
        if (quiet > 0) begin
          quiet--;
          lv = 3'b000;
        end else begin
          for (int b = 0; b < 3; b++)
            if ($urandom_range(0, 3) == 0) lv[b] = ~lv[b];
          if ($urandom_range(0, 59) == 0) quiet = $urandom_range(40, 300);
        end
        hold(1, ($urandom_range(0, 699) == 0), lv, cs);
      end
    end
    hold(300, 1'b0, 3'b000, cs);
  endtask

  // Level of source s as it enters the detector for edge e; reset makes every source look high.
  function automatic bit eff(input int s, input int e);
    if (e < 1 || s_rst[e]) return 1'b1;
    return s_in[e][s];
  endfunction

  task automatic build_model();
    int  last, e, s;
    bit  active, cand, ok;
    last   = -100000;
    active = 1'b0;
    for (int n = 1; n <= npt; n++) begin
      e_ev[n] = 3'b000;
      if (s_rst[n]) begin
        last   = -100000;
        active = 1'b0;
        continue;
      end
      cand = 1'b0;
      e = n - LAT;
      if (e >= 1) begin
        s = int'(s_sel[e]);
        if (s != 3 && !eff(s, e - 1) && eff(s, e)) begin
          ok = 1'b1;
          for (int k = e - 1; k <= e + LAT + 1; k++)
            if (k >= 1 && k <= npt && int'(s_sel[k]) != s) ok = 1'b0;
          for (int k = e; k <= n; k++)
            if (s_rst[k]) ok = 1'b0;
          cand = ok;
        end
      end
      if (cand && (n - last) > DEADTIME) begin
        e_ev[n][0] = 1'b1;
        if (!active) e_ev[n][2] = 1'b1;
        active = 1'b1;
        last   = n;
      end else if (active && (n - last) == GAP_TIMEOUT) begin
        e_ev[n][1] = 1'b1;
        active     = 1'b0;
      end
    end
  endtask

  task automatic apply(input int n);
    rst     = s_rst[n];
    trigin  = s_in[n][0];
    trigcpu = s_in[n][1];
    trigemu = s_in[n][2];
    trigsel = s_sel[n];
    if (e_ev[n] != 3'b000) q.push_back('{stamp: n, kind: e_ev[n]});
  endtask

  initial begin
    build_stim();
    build_model();
    apply(1);
    for (int n = 2; n <= npt; n++) begin
      @(negedge clk);
      apply(n);
    end
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL pending_events: %0d left, next at edge %0d, required 0 left", q.size(), q[0].stamp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    int c;
    logic [2:0] got;
    ev_t ev;
    forever begin
      @(negedge clk);
      c   = cyc;
      got = {cyclebegin, cycleend, trigpulse};
      if (c >= 1 && c <= npt && s_rst[c]) begin
        n_checks++;
        if (got === 3'b000) n_pass++;
        else $display("FAIL reset_outputs: edge %0d got %b required 000", c, got);
      end
      while (q.size() > 0 && q[0].stamp < c) begin
        n_checks++;
        ev = q.pop_front();
        $display("FAIL missed_event: edge %0d got nothing required %b", ev.stamp, ev.kind);
      end
      if (got !== 3'b000) begin
        n_checks++;
        if (q.size() == 0 || q[0].stamp != c) begin
          $display("FAIL unexpected_event: edge %0d got %b required 000", c, got);
        end else begin
          ev = q.pop_front();
          if (ev.kind === got) n_pass++;
          else $display("FAIL event_kind: edge %0d got %b required %b", c, got, ev.kind);
        end
      end
    end
  end
endmodule
